// File: rtl/print_cycle_ctl_pkg.sv
// Shared definitions for the 2821 print-line sequencers: cycle states and
// bar-counter widths reused by sibling printer controllers.
package print_cycle_ctl_pkg;

  localparam int BAR_BIN_W = 8;
  localparam int MAX_SCANS = 63;
  localparam int SCAN_W    = $clog2(MAX_SCANS + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BRST,
    ST_SETTLE,
    ST_CMP,
    ST_ADV,
    ST_CHK,
    ST_DONE
  } cycle_state_e;

  function automatic logic is_busy(input cycle_state_e s);
    return s != ST_IDLE;
  endfunction

endpackage

// File: rtl/print_cycle_ctl_gap_timer.sv
// Print-compare dwell timer: loaded with ADV_GAP-1 ahead of each compare
// window and counted down while comparing; expire_o flags the last cycle.
module gap_timer #(
  parameter int ADV_GAP = 3
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CNT_W = (ADV_GAP > 1) ? $clog2(ADV_GAP) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CNT_W'(ADV_GAP - 1);
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/print_cycle_ctl.sv
// Print-line cycle sequencer: resets and steps the print bar through every
// position for SCANS scans, verifying the bar readback at the end of each scan.
module print_cycle_ctl
  import print_cycle_ctl_pkg::*;
#(
  parameter int POSITIONS = 132,
  parameter int ADV_GAP   = 3,
  parameter int SCANS     = 48
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic                 i_abort,
  input  logic                 i_line_fired,
  input  logic [BAR_BIN_W-1:0] i_bar_binary,
  output logic                 o_bar_reset,
  output logic                 o_bar_advance,
  output logic                 o_print_compare,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_check,
  output logic [SCAN_W-1:0]    o_scan
);

  localparam logic [BAR_BIN_W-1:0] LAST_POS  = BAR_BIN_W'(POSITIONS - 1);
  localparam logic [SCAN_W-1:0]    SCAN_LAST = SCAN_W'(SCANS);

  cycle_state_e         state_q, state_d;
  logic [BAR_BIN_W-1:0] pos_q, pos_d;
  logic [SCAN_W-1:0]    scan_q, scan_d, scan_inc;
  logic                 check_q, check_d;
  logic                 bar_reset_q, bar_advance_q, print_compare_q, busy_q, done_q;
  logic                 gap_load, gap_expire;

  // SETTLE and ADV are the only predecessors of CMP, so loading there arms
  // the timer exactly on entry to every compare window.
  assign gap_load = (state_q == ST_SETTLE) || (state_q == ST_ADV);

  gap_timer #(
    .ADV_GAP (ADV_GAP)
  ) u_gap_timer (
    .clk_i    (i_clk),
    .rst_ni   (i_reset),
    .load_i   (gap_load),
    .en_i     (state_q == ST_CMP),
    .expire_o (gap_expire)
  );

  assign scan_inc = scan_q + 1'b1;

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    scan_d  = scan_q;
    check_d = check_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start && !i_abort) begin
          scan_d  = '0;
          check_d = 1'b0;
          state_d = ST_BRST;
        end
      end
      ST_BRST: begin
        pos_d   = '0;
        state_d = ST_SETTLE;
      end
      ST_SETTLE: state_d = ST_CMP;
      ST_CMP: begin
        if (gap_expire) begin
          state_d = (pos_q < LAST_POS) ? ST_ADV : ST_CHK;
        end
      end
      ST_ADV: begin
        pos_d   = pos_q + 1'b1;
        state_d = ST_CMP;
      end
      ST_CHK: begin
        if (i_bar_binary != LAST_POS) begin
          check_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          scan_d  = scan_inc;
          state_d = ((scan_inc == SCAN_LAST) || i_line_fired) ? ST_DONE : ST_BRST;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Abort freezes the counters and the sticky error where they stand.
    if ((state_q != ST_IDLE) && i_abort) begin
      state_d = ST_IDLE;
      pos_d   = pos_q;
      scan_d  = scan_q;
      check_d = check_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q         <= ST_IDLE;
      pos_q           <= '0;
      scan_q          <= '0;
      check_q         <= 1'b0;
      bar_reset_q     <= 1'b0;
      bar_advance_q   <= 1'b0;
      print_compare_q <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      pos_q           <= pos_d;
      scan_q          <= scan_d;
      check_q         <= check_d;
      bar_reset_q     <= (state_d == ST_BRST);
      bar_advance_q   <= (state_d == ST_ADV);
      print_compare_q <= (state_d == ST_CMP);
      busy_q          <= is_busy(state_d);
      done_q          <= (state_d == ST_DONE);
    end
  end

  assign o_bar_reset     = bar_reset_q;
  assign o_bar_advance   = bar_advance_q;
  assign o_print_compare = print_compare_q;
  assign o_busy          = busy_q;
  assign o_done          = done_q;
  assign o_check         = check_q;
  assign o_scan          = scan_q;

endmodule

// File: tb/tb_print_cycle_ctl.sv
// Bench for print_cycle_ctl: a small configuration checked cycle by cycle
// against a per-scan schedule, plus one full line at the default geometry.
module tb_print_cycle_ctl;

  localparam int SP = 5;
  localparam int SG = 2;
  localparam int SS = 2;
  localparam int SCAN_CYC = 2 + SP * SG + (SP - 1) + 1;

  localparam int PH_IDLE = 0;
  localparam int PH_BRST = 1;
  localparam int PH_SET  = 2;
  localparam int PH_CMP  = 3;
  localparam int PH_ADV  = 4;
  localparam int PH_CHK  = 5;
  localparam int PH_DONE = 6;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       s_start = 1'b0, s_abort = 1'b0, s_fired = 1'b0, s_ovr_en = 1'b0;
  logic [7:0] s_ovr = 8'd3, s_bar = 8'd0, s_bin;
  logic       s_rst, s_adv, s_cmp, s_busy, s_done, s_check;
  logic [5:0] s_scan;

  logic       d_start = 1'b0, d_abort = 1'b0, d_fired = 1'b0;
  logic [7:0] d_bar = 8'd0;
  logic       d_rst, d_adv, d_cmp, d_busy, d_done, d_check;
  logic [5:0] d_scan;

  assign s_bin = s_ovr_en ? s_ovr : s_bar;

  // barsim: bar counter driven by the sequencer pulses
  always @(posedge clk) begin
    if (s_rst) s_bar <= 8'd0;
    else if (s_adv) s_bar <= s_bar + 8'd1;
    if (d_rst) d_bar <= 8'd0;
    else if (d_adv) d_bar <= d_bar + 8'd1;
  end

  print_cycle_ctl #(.POSITIONS(SP), .ADV_GAP(SG), .SCANS(SS)) u_small (
    .i_clk(clk), .i_reset(rst_n), .i_start(s_start), .i_abort(s_abort),
    .i_line_fired(s_fired), .i_bar_binary(s_bin),
    .o_bar_reset(s_rst), .o_bar_advance(s_adv), .o_print_compare(s_cmp),
    .o_busy(s_busy), .o_done(s_done), .o_check(s_check), .o_scan(s_scan));

  print_cycle_ctl #(.POSITIONS(132), .ADV_GAP(3), .SCANS(1)) u_dflt (
    .i_clk(clk), .i_reset(rst_n), .i_start(d_start), .i_abort(d_abort),
    .i_line_fired(d_fired), .i_bar_binary(d_bar),
    .o_bar_reset(d_rst), .o_bar_advance(d_adv), .o_print_compare(d_cmp),
    .o_busy(d_busy), .o_done(d_done), .o_check(d_check), .o_scan(d_scan));

  int total = 0;
  int bad = 0;
  int sched[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // {bar_reset, advance, compare, busy, done}
  function automatic logic [31:0] exp_vec(input int ph);
    case (ph)
      PH_BRST: return 32'b10010;
      PH_SET:  return 32'b00010;
      PH_CMP:  return 32'b00110;
      PH_ADV:  return 32'b01010;
      PH_CHK:  return 32'b00010;
      PH_DONE: return 32'b00011;
      default: return 32'b00000;
    endcase
  endfunction

  function automatic logic [31:0] s_vec();
    return {27'd0, s_rst, s_adv, s_cmp, s_busy, s_done};
  endfunction

  task automatic run_line(input int fire_pct, input int bad_scan, input int abort_idx);
    int  scan;
    int  cyc;
    bit  fin;
    bit  fired;
    bit  badc;
    scan  = 0;
    fin   = 1'b0;
    fired = 1'b0;
    badc  = 1'b0;
    @(negedge clk);
    s_start = 1'b1;
    s_fired = 1'b0;
    @(negedge clk);
    s_start = 1'b0;
    cyc = 1;
    while (!fin) begin
      for (int i = 0; i < SCAN_CYC; i++) begin
        chk("phase", s_vec(), exp_vec(sched[i]));
        chk("scan_cnt", 32'(s_scan), 32'(scan));
        chk("check_low", 32'(s_check), 32'd0);
        s_start = ($urandom_range(0, 7) == 0);
        s_fired = ($urandom_range(0, 99) < fire_pct);
        if (scan == 0 && i == abort_idx) begin
          s_abort = 1'b1;
          @(negedge clk);
          chk("abort_idle", s_vec(), exp_vec(PH_IDLE));
          chk("abort_scan", 32'(s_scan), 32'(scan));
          s_start = 1'b1;
          @(negedge clk);
          chk("abort_start_ignored", s_vec(), exp_vec(PH_IDLE));
          s_start = 1'b0;
          s_abort = 1'b0;
          s_fired = 1'b0;
          return;
        end
        if (i == SCAN_CYC - 1) begin
          fired    = s_fired;
          badc     = (scan == bad_scan);
          s_ovr_en = badc;
        end
        @(negedge clk);
        cyc++;
      end
      s_ovr_en = 1'b0;
      s_start  = 1'b0;
      s_fired  = 1'b0;
      if (badc) begin
        chk("bad_idle", s_vec(), exp_vec(PH_IDLE));
        chk("bad_check", 32'(s_check), 32'd1);
        chk("bad_scan", 32'(s_scan), 32'(scan));
        fin = 1'b1;
      end else begin
        scan++;
        if (scan == SS || fired) begin
          chk("done", s_vec(), exp_vec(PH_DONE));
          chk("done_scan", 32'(s_scan), 32'(scan));
          chk("done_cycle", 32'(cyc), 32'(scan * (2 + SP * SG + (SP - 1) + 1) + 1));
          @(negedge clk);
          chk("after_done", s_vec(), exp_vec(PH_IDLE));
          chk("after_done_chk", 32'(s_check), 32'd0);
          fin = 1'b1;
        end
      end
    end
  endtask

  initial begin
    int cyc;
    int cmp_n;
    int adv_n;
    logic [7:0] last_bar;

    sched.push_back(PH_BRST);
    sched.push_back(PH_SET);
    for (int p = 0; p < SP; p++) begin
      for (int g = 0; g < SG; g++) sched.push_back(PH_CMP);
      if (p < SP - 1) sched.push_back(PH_ADV);
    end
    sched.push_back(PH_CHK);

    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outs", s_vec(), 32'd0);
    chk("reset_scan", 32'(s_scan), 32'd0);
    chk("reset_check", 32'(s_check), 32'd0);
    chk("reset_dflt", {26'd0, d_rst, d_adv, d_cmp, d_busy, d_done, d_check}, 32'd0);
    rst_n = 1'b1;

    run_line(0, -1, -1);
    run_line(100, -1, -1);
    run_line(0, 0, -1);
    chk("check_sticky", 32'(s_check), 32'd1);
    run_line(0, -1, -1);
    run_line(0, -1, 7);
    run_line(0, -1, -1);

    @(negedge clk);
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_reset_cmp", s_vec(), exp_vec(PH_CMP));
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outs", s_vec(), 32'd0);
    chk("async_reset_scan", 32'(s_scan), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_line(0, -1, -1);

    for (int r = 0; r < 6; r++) begin
      run_line($urandom_range(0, 60),
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, SS - 1)) : -1,
               ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, SCAN_CYC - 1)) : -1);
    end

    @(negedge clk);
    d_start = 1'b1;
    @(negedge clk);
    d_start = 1'b0;
    cyc = 1;
    cmp_n = 0;
    adv_n = 0;
    last_bar = 8'd0;
    while (!d_done && cyc < 2000) begin
      last_bar = d_bar;
      if (d_cmp) cmp_n++;
      if (d_adv) adv_n++;
      @(negedge clk);
      cyc++;
    end
    chk("dflt_done_cycle", 32'(cyc), 32'd531);
    chk("dflt_bar_at_chk", 32'(last_bar), 32'd131);
    chk("dflt_compares", 32'(cmp_n), 32'd396);
    chk("dflt_advances", 32'(adv_n), 32'd131);
    chk("dflt_scan", 32'(d_scan), 32'd1);
    chk("dflt_check", 32'(d_check), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
